// File: rtl/dcache_port_arbiter_if.sv
// Bundle of every signal the D-cache port arbiter exchanges with the retire
// stage / store queue head, the load unit and the D-cache.
// slave  : the arbiter's view.
// master : the combined environment (retire, load unit, cache).
interface dcache_port_arbiter_if #(
  parameter int LD_TAG_W = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
);
  // retire store port
  logic                st_req;
  logic [ADDR_W-1:0]   st_addr;
  logic [DATA_W-1:0]   st_data;
  logic [1:0]          st_size;
  logic                st_done;
  // load unit port
  logic                ld_req;
  logic [ADDR_W-1:0]   ld_addr;
  logic [1:0]          ld_size;
  logic [LD_TAG_W-1:0] ld_tag;
  logic                ld_grant;
  logic                ld_resp_valid;
  logic [LD_TAG_W-1:0] ld_resp_tag;
  logic [DATA_W-1:0]   ld_resp_data;
  logic                flush;
  // D-cache port
  logic                dc_req_valid;
  logic                dc_req_store;
  logic [ADDR_W-1:0]   dc_req_addr;
  logic [DATA_W-1:0]   dc_req_data;
  logic [1:0]          dc_req_size;
  logic [LD_TAG_W-1:0] dc_req_tag;
  logic                dc_req_ready;
  logic                dc_resp_valid;
  logic [LD_TAG_W-1:0] dc_resp_tag;
  logic [DATA_W-1:0]   dc_resp_data;

  modport slave (
    input  st_req, st_addr, st_data, st_size,
    output st_done,
    input  ld_req, ld_addr, ld_size, ld_tag,
    output ld_grant, ld_resp_valid, ld_resp_tag, ld_resp_data,
    input  flush,
    output dc_req_valid, dc_req_store, dc_req_addr, dc_req_data, dc_req_size, dc_req_tag,
    input  dc_req_ready, dc_resp_valid, dc_resp_tag, dc_resp_data
  );

  modport master (
    output st_req, st_addr, st_data, st_size,
    input  st_done,
    output ld_req, ld_addr, ld_size, ld_tag,
    input  ld_grant, ld_resp_valid, ld_resp_tag, ld_resp_data,
    output flush,
    input  dc_req_valid, dc_req_store, dc_req_addr, dc_req_data, dc_req_size, dc_req_tag,
    output dc_req_ready, dc_resp_valid, dc_resp_tag, dc_resp_data
  );
endinterface

// File: rtl/dcache_port_arbiter.sv
// D-cache request port arbiter: retire stores vs. the load pipe.
// Stores win by default and complete on acceptance. Loads are tracked per
// tag; a mispredict flush turns every in-flight load into a "zombie" whose
// response is silently dropped, and a tag stays blocked until its response
// has come back.
// Optional build macro DCACHE_ARB_STARVE_GUARD_EN: after STARVE_LIMIT
// consecutive contended losses the load is forced through ahead of the store.
// The width parameters must match those of the connected interface instance.
module dcache_port_arbiter #(
  parameter int LD_TAG_W     = 3,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
`ifdef DCACHE_ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 4
`endif
) (
  input logic                  clock,
  input logic                  reset,
  dcache_port_arbiter_if.slave bus
);

  localparam int N_TAGS = 1 << LD_TAG_W;

  logic [N_TAGS-1:0]   outst_reg, outst_next;
  logic [N_TAGS-1:0]   zombie_reg, zombie_next;
  logic                ld_resp_valid_reg;
  logic [LD_TAG_W-1:0] ld_resp_tag_reg;
  logic [DATA_W-1:0]   ld_resp_data_reg;

  logic tag_blocked;
  logic force_ld;
  logic st_sel;
  logic ld_sel;
  logic st_done;
  logic ld_grant;
  logic resp_fwd;

  // A tag that is still live or still awaiting its squashed response cannot
  // be reissued, otherwise two responses with the same tag could be in flight.
  assign tag_blocked = outst_reg[bus.ld_tag] | zombie_reg[bus.ld_tag];

`ifdef DCACHE_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

  // Count consecutive cycles an eligible load loses to a store; saturate at
  // the limit so a stalled cache cannot wrap the counter past the trigger.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (ld_grant || !bus.ld_req) begin
      starve_cnt_next = '0;
    end else if (bus.st_req && !tag_blocked &&
                 (starve_cnt_reg != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign force_ld = (starve_cnt_reg == CNT_W'(STARVE_LIMIT)) & bus.ld_req & ~tag_blocked;
`else
  assign force_ld = 1'b0;
`endif

  assign st_sel   = bus.st_req & ~force_ld;
  assign ld_sel   = bus.ld_req & ~tag_blocked & (~bus.st_req | force_ld);
  assign st_done  = st_sel & bus.dc_req_ready;
  assign ld_grant = ld_sel & bus.dc_req_ready;

  assign bus.st_done  = st_done;
  assign bus.ld_grant = ld_grant;

  // Drive the cache request from whichever requester was selected; idle
  // fields read as zero so the cache never sees stale data.
  always_comb begin
    bus.dc_req_valid = st_sel | ld_sel;
    bus.dc_req_store = st_sel;
    bus.dc_req_addr  = '0;
    bus.dc_req_data  = '0;
    bus.dc_req_size  = '0;
    bus.dc_req_tag   = '0;
    if (st_sel) begin
      bus.dc_req_addr = bus.st_addr;
      bus.dc_req_data = bus.st_data;
      bus.dc_req_size = bus.st_size;
    end else if (ld_sel) begin
      bus.dc_req_addr = bus.ld_addr;
      bus.dc_req_size = bus.ld_size;
      bus.dc_req_tag  = bus.ld_tag;
    end
  end

  // Per-tag tracking update. A response clears the tag from both vectors
  // before flush migrates live tags to zombie, so a response racing a flush
  // leaves nothing behind. A grant in the flush cycle is born a zombie.
  genvar gi;
  generate
    for (gi = 0; gi < N_TAGS; gi++) begin : g_tag
      logic resp_hit;
      logic grant_hit;
      assign resp_hit  = bus.dc_resp_valid & (bus.dc_resp_tag == LD_TAG_W'(gi));
      assign grant_hit = ld_grant & (bus.ld_tag == LD_TAG_W'(gi));
      assign outst_next[gi]  = (grant_hit & ~bus.flush)
                             | (outst_reg[gi] & ~resp_hit & ~bus.flush);
      assign zombie_next[gi] = (grant_hit & bus.flush)
                             | (zombie_reg[gi] & ~resp_hit)
                             | (outst_reg[gi] & ~resp_hit & bus.flush);
    end
  endgenerate

  // Only a response to a live (non-squashed) load is forwarded, and not one
  // that arrives in the very cycle the flush squashes it.
  assign resp_fwd = bus.dc_resp_valid & outst_reg[bus.dc_resp_tag] & ~bus.flush;

  // Tracking vectors and the registered load-response stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outst_reg         <= '0;
      zombie_reg        <= '0;
      ld_resp_valid_reg <= 1'b0;
      ld_resp_tag_reg   <= '0;
      ld_resp_data_reg  <= '0;
    end else begin
      outst_reg         <= outst_next;
      zombie_reg        <= zombie_next;
      ld_resp_valid_reg <= resp_fwd;
      if (resp_fwd) begin
        ld_resp_tag_reg  <= bus.dc_resp_tag;
        ld_resp_data_reg <= bus.dc_resp_data;
      end
    end
  end

  assign bus.ld_resp_valid = ld_resp_valid_reg;
  assign bus.ld_resp_tag   = ld_resp_tag_reg;
  assign bus.ld_resp_data  = ld_resp_data_reg;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter: directed scenarios followed by
// random traffic, all checked against a per-tag lifecycle model
// (FREE -> LIVE -> FREE, or LIVE -> SQUASHED -> FREE after a flush).
// Build with DCACHE_ARB_STARVE_GUARD_EN to exercise the starvation guard.
module tb_dcache_port_arbiter;
  localparam int TW = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NT = 1 << TW;
  localparam int LIMIT = 4;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int FREE = 0, LIVE = 1, SQUASHED = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  dcache_port_arbiter_if #(.LD_TAG_W(TW), .ADDR_W(AW), .DATA_W(DW)) bus ();

  dcache_port_arbiter #(.LD_TAG_W(TW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int        tstate [NT];
  int        starve;
  bit        e_rv;
  bit [TW-1:0] e_rt;
  bit [DW-1:0] e_rd;
  // last observed grants (sampled before the edge)
  bit obs_grant, obs_st_done;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) tstate[t] = FREE;
    starve = 0;
    e_rv = 1'b0;
    e_rt = '0;
    e_rd = '0;
  endtask

  task automatic idle();
    bus.st_req = 0; bus.st_addr = 0; bus.st_data = 0; bus.st_size = 0;
    bus.ld_req = 0; bus.ld_addr = 0; bus.ld_size = 0; bus.ld_tag = 0;
    bus.flush = 0; bus.dc_req_ready = 1;
    bus.dc_resp_valid = 0; bus.dc_resp_tag = 0; bus.dc_resp_data = 0;
  endtask

  task automatic set_ld(input int tag, input logic [AW-1:0] addr);
    bus.ld_req = 1; bus.ld_tag = TW'(tag); bus.ld_addr = addr; bus.ld_size = 2'd2;
  endtask

  task automatic set_resp(input int tag, input logic [DW-1:0] data);
    bus.dc_resp_valid = 1; bus.dc_resp_tag = TW'(tag); bus.dc_resp_data = data;
  endtask

  // One clock: check the combinational request path, clock, update the
  // model, check the registered response.
  task automatic cycle();
    bit blk, frc, stw, ldw, c_st, c_ld, c_fl, c_rdy, c_rv;
    bit [TW-1:0] c_lt, c_rt;
    bit [DW-1:0] c_rd;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_data;
    logic [1:0]    x_size;
    logic [TW-1:0] x_tag;
    #2;
    c_st = bus.st_req; c_ld = bus.ld_req; c_lt = bus.ld_tag; c_fl = bus.flush;
    c_rdy = bus.dc_req_ready; c_rv = bus.dc_resp_valid; c_rt = bus.dc_resp_tag;
    c_rd = bus.dc_resp_data;
    blk = (tstate[c_lt] != FREE);
    frc = GUARD && (starve == LIMIT) && c_ld && !blk;
    stw = c_st && !frc;
    ldw = c_ld && !blk && (!c_st || frc);
    x_addr = stw ? bus.st_addr : (ldw ? bus.ld_addr : '0);
    x_data = stw ? bus.st_data : '0;
    x_size = stw ? bus.st_size : (ldw ? bus.ld_size : 2'd0);
    x_tag  = ldw ? c_lt : '0;
    obs_grant = bus.ld_grant;
    obs_st_done = bus.st_done;
    chk("st_done", bus.st_done, stw && c_rdy);
    chk("ld_grant", bus.ld_grant, ldw && c_rdy);
    chk("dc_req_valid", bus.dc_req_valid, stw || ldw);
    chk("dc_req_store", bus.dc_req_store, stw);
    chk("dc_req_addr", bus.dc_req_addr, x_addr);
    chk("dc_req_data", bus.dc_req_data, x_data);
    chk("dc_req_size", bus.dc_req_size, x_size);
    chk("dc_req_tag", bus.dc_req_tag, x_tag);
    @(posedge clock);
    #1;
    e_rv = 1'b0;
    if (c_rv) begin
      if (tstate[c_rt] == LIVE) begin
        if (!c_fl) begin e_rv = 1'b1; e_rt = c_rt; e_rd = c_rd; end
        tstate[c_rt] = FREE;
      end else if (tstate[c_rt] == SQUASHED) begin
        tstate[c_rt] = FREE;
      end
    end
    if (c_fl)
      for (int t = 0; t < NT; t++) if (tstate[t] == LIVE) tstate[t] = SQUASHED;
    if (ldw && c_rdy) tstate[c_lt] = c_fl ? SQUASHED : LIVE;
    if ((ldw && c_rdy) || !c_ld) starve = 0;
    else if (c_st && !blk && starve < LIMIT) starve++;
    chk("ld_resp_valid", bus.ld_resp_valid, e_rv);
    if (e_rv) begin
      chk("ld_resp_tag", bus.ld_resp_tag, e_rt);
      chk("ld_resp_data", bus.ld_resp_data, e_rd);
    end
    $display("cyc t=%0t st=%0b ld=%0b tag=%0d fl=%0b rdy=%0b rsp=%0b/%0d -> st_done=%0b ld_grant=%0b resp=%0b",
             $time, c_st, c_ld, c_lt, c_fl, c_rdy, c_rv, c_rt, obs_st_done, obs_grant, bus.ld_resp_valid);
  endtask

  initial begin
    int first_grant;
    int live_q[$];
    idle();
    model_reset();
    reset = 1'b1;
    #12;
    chk("rst_dc_req_valid", bus.dc_req_valid, 1'b0);
    chk("rst_st_done", bus.st_done, 1'b0);
    chk("rst_ld_grant", bus.ld_grant, 1'b0);
    chk("rst_ld_resp_valid", bus.ld_resp_valid, 1'b0);
    chk("rst_ld_resp_tag", bus.ld_resp_tag, '0);
    chk("rst_ld_resp_data", bus.ld_resp_data, '0);
    @(posedge clock); #1;
    reset = 1'b0;

    // store only, ready then not ready
    bus.st_req = 1; bus.st_addr = 32'h100; bus.st_data = 32'h1234_5678; bus.st_size = 2'd2;
    cycle();
    chk("store_done_ready", obs_st_done, 1'b1);
    bus.dc_req_ready = 0;
    cycle();
    chk("store_held_not_ready", obs_st_done, 1'b0);

    // load tag 2, response 0xDEAD two cycles later, tag reusable afterwards
    idle(); set_ld(2, 32'h200);
    cycle();
    chk("ld2_grant", obs_grant, 1'b1);
    idle(); cycle();
    set_resp(2, 32'hDEAD); cycle();
    chk("ld2_resp_valid", bus.ld_resp_valid, 1'b1);
    chk("ld2_resp_tag", bus.ld_resp_tag, 3'd2);
    chk("ld2_resp_data", bus.ld_resp_data, 32'hDEAD);
    idle(); set_ld(2, 32'h204); cycle();
    chk("ld2_regrant", obs_grant, 1'b1);
    idle(); set_resp(2, 32'h55); cycle();

    // grant 1 and 3, flush, zombie responses dropped, tag 1 blocked until then
    idle(); set_ld(1, 32'h10); cycle();
    idle(); set_ld(3, 32'h30); cycle();
    idle(); bus.flush = 1; cycle();
    idle(); set_ld(1, 32'h14); set_resp(1, 32'hAAAA); cycle();
    chk("zombie_blocks_tag1", obs_grant, 1'b0);
    chk("zombie1_dropped", bus.ld_resp_valid, 1'b0);
    idle(); set_ld(1, 32'h14); set_resp(3, 32'hBBBB); cycle();
    chk("tag1_after_zombie", obs_grant, 1'b1);
    chk("zombie3_dropped", bus.ld_resp_valid, 1'b0);
    idle(); set_resp(1, 32'hCCCC); cycle();
    chk("tag1_live_resp", bus.ld_resp_valid, 1'b1);

    // contention: store held against load tag 4
    idle();
    bus.st_req = 1; bus.st_addr = 32'h300; bus.st_data = 32'h77; bus.st_size = 2'd1;
    set_ld(4, 32'h400);
    first_grant = -1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (obs_grant && first_grant < 0) first_grant = i;
    end
    chk("starve_first_grant", 64'(first_grant), GUARD ? 64'(4) : 64'(-1));
    idle(); set_resp(4, 32'h4444); cycle();

    // async reset with tag 5 outstanding discards tracking
    idle(); set_ld(5, 32'h500); cycle();
    idle();
    reset = 1'b1;
    #2;
    chk("async_reset_resp_valid", bus.ld_resp_valid, 1'b0);
    reset = 1'b0;
    model_reset();
    set_resp(5, 32'h5555); cycle();
    chk("post_reset_resp5_dropped", bus.ld_resp_valid, 1'b0);
    idle(); set_ld(5, 32'h504); cycle();
    chk("post_reset_tag5_grant", obs_grant, 1'b1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      bus.st_req  = $urandom_range(0, 1);
      bus.st_addr = $urandom; bus.st_data = $urandom; bus.st_size = 2'($urandom_range(0, 2));
      bus.ld_req  = $urandom_range(0, 1);
      bus.ld_addr = $urandom; bus.ld_size = 2'($urandom_range(0, 2));
      bus.ld_tag  = TW'($urandom_range(0, NT - 1));
      bus.flush   = ($urandom_range(0, 15) == 0);
      bus.dc_req_ready = ($urandom_range(0, 3) != 0);
      live_q.delete();
      for (int t = 0; t < NT; t++) if (tstate[t] != FREE) live_q.push_back(t);
      bus.dc_resp_valid = $urandom_range(0, 1);
      if (live_q.size() > 0 && $urandom_range(0, 3) != 0)
        bus.dc_resp_tag = TW'(live_q[$urandom_range(0, live_q.size() - 1)]);
      else
        bus.dc_resp_tag = TW'($urandom_range(0, NT - 1));
      bus.dc_resp_data = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
